// File: rtl/if_id.sv
// IF/ID pipeline register: carries the fetched instruction and its PC into decode,
// with hazard-unit stall and branch/jump flush.
module if_id #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  NOP_WORD = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] InsIn,
    input  logic [WIDTH-1:0] PC_In,
    input  logic             IFID_write,
    input  logic             IF_flush,
    output logic [WIDTH-1:0] InsOut,
    output logic [WIDTH-1:0] PC_out
);

    logic [WIDTH-1:0] insReg;
    logic [WIDTH-1:0] pcReg;

    // A flush squashes the ID slot even while stalled, so it is checked before the write enable.
    always_ff @(posedge clk) begin
        if (reset || IF_flush) begin
            insReg <= NOP_WORD;
            pcReg  <= '0;
        end else if (IFID_write) begin
            insReg <= InsIn;
            pcReg  <= PC_In;
        end
    end

    assign InsOut = insReg;
    assign PC_out = pcReg;

endmodule

// File: tb/tb_if_id.sv
// Directed and random self-checking bench for the IF/ID pipeline register.
module tb_if_id;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] InsIn;
    logic [WIDTH-1:0] PC_In;
    logic             IFID_write;
    logic             IF_flush;
    logic [WIDTH-1:0] InsOut;
    logic [WIDTH-1:0] PC_out;

    int testsRun    = 0;
    int testsFailed = 0;

    if_id #(.WIDTH(WIDTH), .NOP_WORD(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .InsIn      (InsIn),
        .PC_In      (PC_In),
        .IFID_write (IFID_write),
        .IF_flush   (IF_flush),
        .InsOut     (InsOut),
        .PC_out     (PC_out)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge, away from the capturing edge.
    task automatic drive(input logic rst, input logic [WIDTH-1:0] ins,
                         input logic [WIDTH-1:0] pc, input logic wr, input logic fl);
        @(negedge clk);
        reset      = rst;
        InsIn      = ins;
        PC_In      = pc;
        IFID_write = wr;
        IF_flush   = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input logic [WIDTH-1:0] ins,
                             input logic [WIDTH-1:0] pc);
        checkVal({tag, ".ins"}, InsOut, ins);
        checkVal({tag, ".pc"},  PC_out, pc);
    endtask

    initial begin
        reset      = 1'b1;
        InsIn      = 32'hDEAD_BEEF;
        PC_In      = 32'h0040_0004;
        IFID_write = 1'b1;
        IF_flush   = 1'b0;

        tick();
        expectOut("reset1", 32'h0, 32'h0);
        tick();
        expectOut("reset2", 32'h0, 32'h0);
        drive(1'b0, 32'hDEAD_BEEF, 32'h0040_0004, 1'b1, 1'b0);
        tick();
        expectOut("resetRelease", 32'hDEAD_BEEF, 32'h0040_0004);

        drive(1'b0, 32'h8C22_0004, 32'h0040_0008, 1'b1, 1'b0);
        tick();
        expectOut("stallPre", 32'h8C22_0004, 32'h0040_0008);
        drive(1'b0, 32'h0043_0820, 32'h0040_000C, 1'b0, 1'b0);
        tick();
        expectOut("stallHold", 32'h8C22_0004, 32'h0040_0008);
        drive(1'b0, 32'h0043_0820, 32'h0040_000C, 1'b1, 1'b0);
        tick();
        expectOut("stallResume", 32'h0043_0820, 32'h0040_000C);

        drive(1'b0, 32'h1022_0003, 32'h0040_000C, 1'b1, 1'b0);
        tick();
        expectOut("flushPre", 32'h1022_0003, 32'h0040_000C);
        drive(1'b0, 32'h1234_5678, 32'h0040_0010, 1'b1, 1'b1);
        tick();
        expectOut("flush", 32'h0, 32'h0);
        drive(1'b0, 32'h1234_5678, 32'h0040_0010, 1'b1, 1'b0);
        tick();
        expectOut("flushResume", 32'h1234_5678, 32'h0040_0010);

        drive(1'b0, 32'hAC43_0008, 32'h0040_0014, 1'b1, 1'b0);
        tick();
        expectOut("flushStallPre", 32'hAC43_0008, 32'h0040_0014);
        drive(1'b0, 32'h0800_0010, 32'h0040_0018, 1'b0, 1'b1);
        tick();
        expectOut("flushStall", 32'h0, 32'h0);
        drive(1'b0, 32'h0800_0010, 32'h0040_0018, 1'b0, 1'b0);
        tick();
        expectOut("nopHeld", 32'h0, 32'h0);
        drive(1'b0, 32'h0800_0010, 32'h0040_0018, 1'b1, 1'b0);
        tick();
        expectOut("nopRelease", 32'h0800_0010, 32'h0040_0018);

        drive(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
        tick();
        expectOut("resetMid", 32'h0, 32'h0);
        drive(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
        tick();
        expectOut("resetFlushStall", 32'h0, 32'h0);
        drive(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
        tick();
        expectOut("resetMidRelease", 32'hFFFF_FFFF, 32'h8000_0000);

        for (int i = 0; i < 1000; i++) begin
            logic [WIDTH-1:0] ins, pc;
            ins = $urandom;
            pc  = $urandom;
            drive(1'b0, ins, pc, 1'b1, 1'b0);
            tick();
            expectOut("passThru", ins, pc);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
